tcm_pmem_axi_port: RTL and testbench
====================================

# tcm_pmem_axi_port

Parametrised AXI slave port into the single-port TCM SRAM of the single-cycle core's memory subsystem. Accepts single-beat AXI4 reads and writes and arbitrates them onto one SRAM port. Arbitration is configurable as write-priority or round-robin, and out-of-range addresses receive an error response. Read/write pending state is held in registers that reset to idle, so no memory access is ever issued during or immediately after reset.

## Interface
Parameters:
- ADDR_W, 32: AXI address width.
- DATA_W, 32: data width; must be 32 or 64.
- MEM_ADDR_W, 14: SRAM word-address width; capacity is 2^MEM_ADDR_W words.
- ID_W, 4: AXI ID width.
- ARB_MODE, 0: 0 = write priority, 1 = round-robin.

Ports (all single-beat; AWLEN/ARLEN not supported):
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- axi_awvalid_i / axi_awready_o  in/out  1  write-address handshake.
- axi_awaddr_i  in  ADDR_W  write address.
- axi_awid_i  in  ID_W  write ID.
- axi_wvalid_i / axi_wready_o  in/out  1  write-data handshake.
- axi_wdata_i  in  DATA_W  write data.
- axi_wstrb_i  in  DATA_W/8  byte strobes.
- axi_bvalid_o / axi_bready_i  out/in  1  write-response handshake.
- axi_bresp_o  out  2  write response code.
- axi_bid_o  out  ID_W  write-response ID.
- axi_arvalid_i / axi_arready_o  in/out  1  read-address handshake.
- axi_araddr_i  in  ADDR_W  read address.
- axi_arid_i  in  ID_W  read ID.
- axi_rvalid_o / axi_rready_i  out/in  1  read-data handshake.
- axi_rdata_o  out  DATA_W  read data.
- axi_rresp_o  out  2  read response code.
- axi_rid_o  out  ID_W  read ID.
- axi_rlast_o  out  1  tied 1.
- ram_addr_o  out  MEM_ADDR_W  SRAM word address.
- ram_wr_o  out  DATA_W/8  byte write enables.
- ram_rd_o  out  1  SRAM read enable.
- ram_wdata_o  out  DATA_W  SRAM write data.
- ram_rdata_i  in  DATA_W  SRAM read data; valid exactly 1 cycle after ram_rd_o.

## Operation
- States: IDLE, RD_WAIT, RD_RESP, WR_RESP. Reset enters IDLE.
- Write acceptance (IDLE): axi_awready_o and axi_wready_o assert together only when both valids are high and write is granted.
- Read acceptance (IDLE): axi_arready_o asserts when arvalid is high and read is granted.
- Arbitration, ARB_MODE=0: write wins whenever both are pending.
- Arbitration, ARB_MODE=1: the winner alternates on contention. last_grant resets to READ, so the first contended cycle grants write. last_grant updates on every grant.
- Memory issue happens in the handshake cycle itself, combinationally:
  - ram_addr_o = granted AXI address bits [MEM_ADDR_W+OFF-1:OFF], where OFF = log2(DATA_W/8).
  - Writes drive ram_wr_o = wstrb.
  - Reads drive ram_rd_o = 1.
- Out-of-range access: any address bit at or above MEM_ADDR_W+OFF is set.
  - No ram strobe is issued.
  - Response is SLVERR (2'b10); read data is 0.
  - Otherwise the response is OKAY (2'b00).
- Write path: handshake, then WR_RESP with bvalid=1 and bid = captured awid.
- Read path: handshake, then RD_WAIT (capture ram_rdata_i into rdata_q), then RD_RESP with rvalid=1. rdata_o is held stable until rready.
- Leaving a response state: on bready/rready the block returns to IDLE and may accept a new request in that same cycle.
- Outside a handshake cycle, ram_addr_o holds the last issued address and all ram strobes are 0.

## Timing
- Reset values:
  - All AXI ready/valid outputs 0; bresp/rresp/bid/rid/rdata 0; rlast 1.
  - ram_wr_o 0, ram_rd_o 0, ram_addr_o 0.
  - Internal req_rd_q/req_wr_q 0; last_grant = READ.
- Write latency: bvalid asserts 1 cycle after the AW/W handshake.
- Read latency: rvalid asserts 2 cycles after the AR handshake.
- Peak throughput: one write every cycle (back-to-back with bready held high); one read every 2 cycles.
- A response, once asserted, holds valid and payload stable until its ready is seen.
- AW valid without W valid (or the reverse) is never accepted; a pending AR may be granted instead.
- Reset mid-transaction: any in-flight response is dropped and no ram strobe is issued in the reset cycle or the cycle after.

## Structure
- Package tcm_pmem_pkg holds:
  - AXI_RESP_OKAY = 2'b00, AXI_RESP_SLVERR = 2'b10.
  - State enum tcm_port_state_t.
  - ARB_WRITE_PRIO = 0, ARB_ROUND_ROBIN = 1.
- Sub-module tcm_pmem_arb: 2-requester grant logic with the ARB_MODE parameter and the last_grant register.

## Test plan
- Reset release with awvalid, wvalid and arvalid all high in the first cycle -> no ram strobe while rst_i=1; after release, first grant is the write.
- Write 0xDEADBEEF, wstrb 4'b0011, addr 0x10, id 3 -> ram_wr_o=0011 and ram_addr_o=4 in the handshake cycle; bvalid next cycle with bid=3, bresp=00.
- Read addr 0x10 with SRAM returning 0x1234_5678 -> rvalid 2 cycles later, rdata=0x12345678; with rready held low 5 cycles, rdata stays stable.
- ARB_MODE=1, continuous simultaneous write and read requests -> grants alternate W,R,W,R; with ARB_MODE=0 only writes are granted.
- Read addr 0x0001_0000 (MEM_ADDR_W=14) -> no ram_rd_o, rresp=10, rdata=0.
- Assert rst_i while in RD_RESP -> rvalid drops to 0 the next cycle; block returns to IDLE.

Source files
------------

// File: rtl/tcm_pmem_pkg.sv
// Shared constants and types for the TCM program-memory AXI slave port.
package tcm_pmem_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam int unsigned ARB_WRITE_PRIO  = 0;
    localparam int unsigned ARB_ROUND_ROBIN = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_RESP,
        ST_WR_RESP
    } tcm_port_state_t;

    typedef enum logic {
        GRANT_READ  = 1'b0,
        GRANT_WRITE = 1'b1
    } tcm_grant_t;

endpackage

// File: rtl/tcm_pmem_arb.sv
// Two-requester grant logic: fixed write priority or alternating on contention.
module tcm_pmem_arb
    import tcm_pmem_pkg::*;
#(
    parameter int unsigned ARB_MODE = ARB_WRITE_PRIO
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic wr_req_i,
    input  logic rd_req_i,
    output logic wr_gnt_o,
    output logic rd_gnt_o
);

    tcm_grant_t last_grant_q, last_grant_d;

    always_comb begin
        wr_gnt_o = 1'b0;
        rd_gnt_o = 1'b0;
        if (en_i) begin
            if (wr_req_i && rd_req_i && (ARB_MODE == ARB_ROUND_ROBIN)) begin
                wr_gnt_o = (last_grant_q == GRANT_READ);
                rd_gnt_o = (last_grant_q == GRANT_WRITE);
            end else begin
                wr_gnt_o = wr_req_i;
                rd_gnt_o = rd_req_i && !wr_req_i;
            end
        end
        last_grant_d = last_grant_q;
        if (wr_gnt_o) begin
            last_grant_d = GRANT_WRITE;
        end else if (rd_gnt_o) begin
            last_grant_d = GRANT_READ;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant_q <= GRANT_READ;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/tcm_pmem_axi_port.sv
// Single-beat AXI4 slave port arbitrating reads and writes onto one TCM SRAM port.
module tcm_pmem_axi_port
    import tcm_pmem_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MEM_ADDR_W = 14,
    parameter int unsigned ID_W       = 4,
    parameter int unsigned ARB_MODE   = ARB_WRITE_PRIO
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    axi_awvalid_i,
    output logic                    axi_awready_o,
    input  logic [ADDR_W-1:0]       axi_awaddr_i,
    input  logic [ID_W-1:0]         axi_awid_i,
    input  logic                    axi_wvalid_i,
    output logic                    axi_wready_o,
    input  logic [DATA_W-1:0]       axi_wdata_i,
    input  logic [DATA_W/8-1:0]     axi_wstrb_i,
    output logic                    axi_bvalid_o,
    input  logic                    axi_bready_i,
    output logic [1:0]              axi_bresp_o,
    output logic [ID_W-1:0]         axi_bid_o,
    input  logic                    axi_arvalid_i,
    output logic                    axi_arready_o,
    input  logic [ADDR_W-1:0]       axi_araddr_i,
    input  logic [ID_W-1:0]         axi_arid_i,
    output logic                    axi_rvalid_o,
    input  logic                    axi_rready_i,
    output logic [DATA_W-1:0]       axi_rdata_o,
    output logic [1:0]              axi_rresp_o,
    output logic [ID_W-1:0]         axi_rid_o,
    output logic                    axi_rlast_o,
    output logic [MEM_ADDR_W-1:0]   ram_addr_o,
    output logic [DATA_W/8-1:0]     ram_wr_o,
    output logic                    ram_rd_o,
    output logic [DATA_W-1:0]       ram_wdata_o,
    input  logic [DATA_W-1:0]       ram_rdata_i
);

    localparam int unsigned OFF = $clog2(DATA_W / 8);
    localparam int unsigned TOP = MEM_ADDR_W + OFF;

    tcm_port_state_t       state_q, state_d;
    logic                  en_q;
    logic [ID_W-1:0]       bid_q, bid_d, rid_q, rid_d;
    logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  rd_oor_q, rd_oor_d;
    logic [MEM_ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic                  accept, wr_gnt, rd_gnt, aw_oor, ar_oor;
    logic                  unused_addr_lsbs;

    assign aw_oor           = |(axi_awaddr_i >> TOP);
    assign ar_oor           = |(axi_araddr_i >> TOP);
    assign unused_addr_lsbs = ^{axi_awaddr_i[OFF-1:0], axi_araddr_i[OFF-1:0]};

    // en_q holds off acceptance for one cycle after reset so no strobe follows it directly.
    always_comb begin
        accept = 1'b0;
        if (!rst_i && en_q) begin
            case (state_q)
                ST_IDLE:    accept = 1'b1;
                ST_WR_RESP: accept = axi_bready_i;
                ST_RD_RESP: accept = axi_rready_i;
                default:    accept = 1'b0;
            endcase
        end
    end

    tcm_pmem_arb #(
        .ARB_MODE(ARB_MODE)
    ) u_arb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (accept),
        .wr_req_i (axi_awvalid_i && axi_wvalid_i),
        .rd_req_i (axi_arvalid_i),
        .wr_gnt_o (wr_gnt),
        .rd_gnt_o (rd_gnt)
    );

    always_comb begin
        state_d    = state_q;
        bid_d      = bid_q;
        rid_d      = rid_q;
        bresp_d    = bresp_q;
        rresp_d    = rresp_q;
        rdata_d    = rdata_q;
        rd_oor_d   = rd_oor_q;
        ram_addr_d = ram_addr_q;
        ram_wr_o   = '0;
        ram_rd_o   = 1'b0;

        case (state_q)
            ST_WR_RESP: if (axi_bready_i) state_d = ST_IDLE;
            ST_RD_WAIT: begin
                state_d = ST_RD_RESP;
                rdata_d = rd_oor_q ? '0 : ram_rdata_i;
            end
            ST_RD_RESP: if (axi_rready_i) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        // A grant overrides the return to idle so a new request starts in the same cycle.
        if (wr_gnt) begin
            state_d    = ST_WR_RESP;
            bid_d      = axi_awid_i;
            bresp_d    = aw_oor ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            ram_addr_d = axi_awaddr_i[TOP-1:OFF];
            ram_wr_o   = aw_oor ? '0 : axi_wstrb_i;
        end else if (rd_gnt) begin
            state_d    = ST_RD_WAIT;
            rid_d      = axi_arid_i;
            rresp_d    = ar_oor ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
            rd_oor_d   = ar_oor;
            ram_addr_d = axi_araddr_i[TOP-1:OFF];
            ram_rd_o   = !ar_oor;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            en_q       <= 1'b0;
            bid_q      <= '0;
            rid_q      <= '0;
            bresp_q    <= AXI_RESP_OKAY;
            rresp_q    <= AXI_RESP_OKAY;
            rdata_q    <= '0;
            rd_oor_q   <= 1'b0;
            ram_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            en_q       <= 1'b1;
            bid_q      <= bid_d;
            rid_q      <= rid_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            rd_oor_q   <= rd_oor_d;
            ram_addr_q <= ram_addr_d;
        end
    end

    assign axi_awready_o = wr_gnt;
    assign axi_wready_o  = wr_gnt;
    assign axi_arready_o = rd_gnt;
    assign axi_bvalid_o  = (state_q == ST_WR_RESP);
    assign axi_bresp_o   = bresp_q;
    assign axi_bid_o     = bid_q;
    assign axi_rvalid_o  = (state_q == ST_RD_RESP);
    assign axi_rdata_o   = rdata_q;
    assign axi_rresp_o   = rresp_q;
    assign axi_rid_o     = rid_q;
    assign axi_rlast_o   = 1'b1;
    assign ram_addr_o    = ram_addr_d;
    assign ram_wdata_o   = axi_wdata_i;

endmodule

// File: tb/tb_tcm_pmem_axi_port.sv
// Bench for tcm_pmem_axi_port: write-priority and round-robin instances driven in parallel.
module tb_tcm_pmem_axi_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        awvalid, wvalid, arvalid, bready, rready;
    logic [31:0] awaddr, araddr, wdata;
    logic [3:0]  wstrb, awid, arid;

    logic        awready [2], wready [2], bvalid [2], arready [2], rvalid [2], rlast [2], ram_rd [2];
    logic [1:0]  bresp [2], rresp [2];
    logic [3:0]  bid [2], rid [2], ram_wr [2];
    logic [31:0] rdata [2], ram_wdata [2], ram_rdata [2];
    logic [13:0] ram_addr [2];

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    tcm_pmem_axi_port #(
        .ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(14), .ID_W(4), .ARB_MODE(0)
    ) u_dut_wp (
        .clk_i(clk), .rst_i(rst),
        .axi_awvalid_i(awvalid), .axi_awready_o(awready[0]), .axi_awaddr_i(awaddr), .axi_awid_i(awid),
        .axi_wvalid_i(wvalid), .axi_wready_o(wready[0]), .axi_wdata_i(wdata), .axi_wstrb_i(wstrb),
        .axi_bvalid_o(bvalid[0]), .axi_bready_i(bready), .axi_bresp_o(bresp[0]), .axi_bid_o(bid[0]),
        .axi_arvalid_i(arvalid), .axi_arready_o(arready[0]), .axi_araddr_i(araddr), .axi_arid_i(arid),
        .axi_rvalid_o(rvalid[0]), .axi_rready_i(rready), .axi_rdata_o(rdata[0]), .axi_rresp_o(rresp[0]),
        .axi_rid_o(rid[0]), .axi_rlast_o(rlast[0]),
        .ram_addr_o(ram_addr[0]), .ram_wr_o(ram_wr[0]), .ram_rd_o(ram_rd[0]),
        .ram_wdata_o(ram_wdata[0]), .ram_rdata_i(ram_rdata[0])
    );

    tcm_pmem_axi_port #(
        .ADDR_W(32), .DATA_W(32), .MEM_ADDR_W(14), .ID_W(4), .ARB_MODE(1)
    ) u_dut_rr (
        .clk_i(clk), .rst_i(rst),
        .axi_awvalid_i(awvalid), .axi_awready_o(awready[1]), .axi_awaddr_i(awaddr), .axi_awid_i(awid),
        .axi_wvalid_i(wvalid), .axi_wready_o(wready[1]), .axi_wdata_i(wdata), .axi_wstrb_i(wstrb),
        .axi_bvalid_o(bvalid[1]), .axi_bready_i(bready), .axi_bresp_o(bresp[1]), .axi_bid_o(bid[1]),
        .axi_arvalid_i(arvalid), .axi_arready_o(arready[1]), .axi_araddr_i(araddr), .axi_arid_i(arid),
        .axi_rvalid_o(rvalid[1]), .axi_rready_i(rready), .axi_rdata_o(rdata[1]), .axi_rresp_o(rresp[1]),
        .axi_rid_o(rid[1]), .axi_rlast_o(rlast[1]),
        .ram_addr_o(ram_addr[1]), .ram_wr_o(ram_wr[1]), .ram_rd_o(ram_rd[1]),
        .ram_wdata_o(ram_wdata[1]), .ram_rdata_i(ram_rdata[1])
    );

    // Unwritten SRAM words read back as a fixed address-derived pattern; word 4 holds 0x12345678.
    function automatic logic [31:0] pattern(input logic [13:0] a);
        if (a == 14'd4) return 32'h1234_5678;
        return {18'd0, a} * 32'h9E37_79B1;
    endfunction

    task automatic chk(input string name, input int k, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d: got 0x%0h want 0x%0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Behavioural SRAM per instance: read data appears one cycle after ram_rd.
    logic [31:0] mem [2][16384];
    bit          written [2][16384];
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [31:0] cur;
            cur = written[k][ram_addr[k]] ? mem[k][ram_addr[k]] : pattern(ram_addr[k]);
            if (ram_rd[k] === 1'b1) ram_rdata[k] <= cur;
            if (ram_wr[k] !== 4'h0 && !$isunknown(ram_wr[k])) begin
                for (int b = 0; b < 4; b++)
                    if (ram_wr[k][b]) cur[8*b +: 8] = ram_wdata[k][8*b +: 8];
                mem[k][ram_addr[k]]     <= cur;
                written[k][ram_addr[k]] <= 1'b1;
            end
        end
    end

    // Transaction-level model: one outstanding response per port with a visibility delay.
    bit          m_have [2];
    bit          m_rd [2];
    int          m_wait [2];
    int          m_cool [2]  = '{1, 1};
    bit          m_lastw [2];
    bit          m_reset [2] = '{1, 1};
    logic [3:0]  m_id [2];
    logic [1:0]  m_resp [2];
    logic [31:0] m_data [2];
    logic [31:0] shadow [2][16384];
    bit          s_written [2][16384];

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < 2; k++) begin
                bit          vis, rdy, open, wq, rq, gw, gr, aw_oor, ar_oor;
                logic [3:0]  exp_wr;
                logic [13:0] aw_word, ar_word;
                logic [31:0] cur;
                aw_oor  = awaddr >= 32'h0001_0000;
                ar_oor  = araddr >= 32'h0001_0000;
                aw_word = 14'((awaddr / 4) % 16384);
                ar_word = 14'((araddr / 4) % 16384);
                vis  = m_have[k] && (m_wait[k] == 0);
                rdy  = m_rd[k] ? rready : bready;
                open = !rst && (m_cool[k] == 0) && (!m_have[k] || (vis && rdy));
                wq   = open && awvalid && wvalid;
                rq   = open && arvalid;
                gw   = 1'b0;
                gr   = 1'b0;
                if (wq && rq) begin
                    if (k == 1 && m_lastw[k]) gr = 1'b1;
                    else gw = 1'b1;
                end else begin
                    gw = wq;
                    gr = rq;
                end
                exp_wr = (gw && !aw_oor) ? wstrb : 4'h0;

                chk("awready", k, awready[k], gw);
                chk("wready", k, wready[k], gw);
                chk("arready", k, arready[k], gr);
                chk("ram_wr", k, ram_wr[k], exp_wr);
                chk("ram_rd", k, ram_rd[k], gr && !ar_oor);
                if (exp_wr != 4'h0) begin
                    chk("ram_addr_wr", k, ram_addr[k], aw_word);
                    chk("ram_wdata", k, ram_wdata[k], wdata);
                end
                if (gr && !ar_oor) chk("ram_addr_rd", k, ram_addr[k], ar_word);
                if (m_reset[k]) begin
                    chk("rst_ram_addr", k, ram_addr[k], 0);
                    chk("rst_bid", k, bid[k], 0);
                    chk("rst_rid", k, rid[k], 0);
                    chk("rst_bresp", k, bresp[k], 0);
                    chk("rst_rresp", k, rresp[k], 0);
                    chk("rst_rdata", k, rdata[k], 0);
                end
                chk("bvalid", k, bvalid[k], vis && !m_rd[k]);
                chk("rvalid", k, rvalid[k], vis && m_rd[k]);
                chk("rlast", k, rlast[k], 1);
                if (vis && !m_rd[k]) begin
                    chk("bid", k, bid[k], m_id[k]);
                    chk("bresp", k, bresp[k], m_resp[k]);
                end
                if (vis && m_rd[k]) begin
                    chk("rid", k, rid[k], m_id[k]);
                    chk("rresp", k, rresp[k], m_resp[k]);
                    chk("rdata", k, rdata[k], m_data[k]);
                end

                if (rst) begin
                    m_have[k]  = 1'b0;
                    m_cool[k]  = 1;
                    m_lastw[k] = 1'b0;
                    m_reset[k] = 1'b1;
                end else begin
                    m_reset[k] = 1'b0;
                    if (m_cool[k] > 0) begin
                        m_cool[k]--;
                    end else begin
                        if (m_have[k]) begin
                            if (m_wait[k] > 0) m_wait[k]--;
                            else if (rdy) m_have[k] = 1'b0;
                        end
                        if (gw) begin
                            m_have[k]  = 1'b1;
                            m_rd[k]    = 1'b0;
                            m_wait[k]  = 0;
                            m_id[k]    = awid;
                            m_resp[k]  = aw_oor ? 2'b10 : 2'b00;
                            m_lastw[k] = 1'b1;
                            if (!aw_oor) begin
                                cur = s_written[k][aw_word] ? shadow[k][aw_word] : pattern(aw_word);
                                for (int b = 0; b < 4; b++)
                                    if (wstrb[b]) cur[8*b +: 8] = wdata[8*b +: 8];
                                shadow[k][aw_word]    = cur;
                                s_written[k][aw_word] = 1'b1;
                            end
                        end
                        if (gr) begin
                            m_have[k]  = 1'b1;
                            m_rd[k]    = 1'b1;
                            m_wait[k]  = 1;
                            m_id[k]    = arid;
                            m_resp[k]  = ar_oor ? 2'b10 : 2'b00;
                            m_lastw[k] = 1'b0;
                            if (ar_oor) m_data[k] = 32'h0;
                            else m_data[k] = s_written[k][ar_word] ? shadow[k][ar_word] : pattern(ar_word);
                        end
                    end
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        awaddr = 32'h20; wdata = 32'hA5A5_0F0F; wstrb = 4'hF; awid = 4'd1;
        araddr = 32'h24; arid = 4'd2;
        bready = 1'b1; rready = 1'b1;

        @(posedge clk);
        chk_on = 1'b1;
        repeat (2) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk("lit_rst_no_wr", k, ram_wr[k], 0);
                chk("lit_rst_no_rd", k, ram_rd[k], 0);
            end
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("lit_post_rst_no_wr", k, ram_wr[k], 0);
            chk("lit_post_rst_no_aw", k, awready[k], 0);
        end

        // Continuous contention: write-priority always writes, round-robin goes W, R, (wait), W, R, (wait).
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("lit_wp_aw", 0, awready[0], 1);
            chk("lit_wp_ar", 0, arready[0], 0);
            chk("lit_rr_aw", 1, awready[1], (i % 3) == 0);
            chk("lit_rr_ar", 1, arready[1], (i % 3) == 1);
            if (i == 0) begin
                for (int k = 0; k < 2; k++) begin
                    chk("lit_first_wr", k, ram_wr[k], 4'hF);
                    chk("lit_first_addr", k, ram_addr[k], 14'd8);
                end
            end
        end
        tick;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        repeat (3) tick;

        // Read of word 4 with rready held low for five response cycles.
        arvalid = 1'b1; araddr = 32'h10; arid = 4'd5; rready = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("lit_rd_issue", k, ram_rd[k], 1);
            chk("lit_rd_addr", k, ram_addr[k], 14'd4);
        end
        tick;
        arvalid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk("lit_rd_wait", k, rvalid[k], 0);
        repeat (5) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk("lit_rd_valid", k, rvalid[k], 1);
                chk("lit_rd_data", k, rdata[k], 32'h1234_5678);
                chk("lit_rd_id", k, rid[k], 4'd5);
            end
        end
        tick;
        rready = 1'b1;

        // Out-of-range read.
        tick;
        arvalid = 1'b1; araddr = 32'h0001_0000; arid = 4'd7;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("lit_oor_ar", k, arready[k], 1);
            chk("lit_oor_no_rd", k, ram_rd[k], 0);
        end
        tick;
        arvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("lit_oor_rvalid", k, rvalid[k], 1);
            chk("lit_oor_rresp", k, rresp[k], 2'b10);
            chk("lit_oor_rdata", k, rdata[k], 0);
        end

        // Partial write then read-back of the merged word.
        tick;
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'h10; wdata = 32'hDEAD_BEEF; wstrb = 4'b0011; awid = 4'd3;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("lit_wr_strb", k, ram_wr[k], 4'b0011);
            chk("lit_wr_addr", k, ram_addr[k], 14'd4);
        end
        tick;
        awvalid = 1'b0; wvalid = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("lit_wr_bvalid", k, bvalid[k], 1);
            chk("lit_wr_bid", k, bid[k], 4'd3);
            chk("lit_wr_bresp", k, bresp[k], 2'b00);
        end
        tick;
        arvalid = 1'b1; araddr = 32'h10; arid = 4'd1;
        tick;
        arvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk("lit_readback", k, rdata[k], 32'h1234_BEEF);

        // Out-of-range write with bready held low while a read waits; the read is taken on bready.
        tick;
        awvalid = 1'b1; wvalid = 1'b1; awaddr = 32'h8000_0000; wstrb = 4'hF; awid = 4'd9; bready = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk("lit_oor_no_wr", k, ram_wr[k], 0);
        tick;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b1; araddr = 32'h24; arid = 4'd4;
        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                chk("lit_oor_bresp", k, bresp[k], 2'b10);
                chk("lit_oor_bid", k, bid[k], 4'd9);
                chk("lit_hold_no_ar", k, arready[k], 0);
            end
        end
        tick;
        bready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("lit_same_cycle_b", k, bvalid[k], 1);
            chk("lit_same_cycle_ar", k, arready[k], 1);
        end
        tick;
        arvalid = 1'b0;
        repeat (3) tick;

        // Reset asserted while a read response is pending.
        arvalid = 1'b1; araddr = 32'h14; arid = 4'd6; rready = 1'b0;
        tick;
        arvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk("lit_pre_rst_rvalid", k, rvalid[k], 1);
        tick;
        rst = 1'b1; arvalid = 1'b1; araddr = 32'h18; arid = 4'd8;
        @(negedge clk);
        for (int k = 0; k < 2; k++) chk("lit_rst_cyc_no_rd", k, ram_rd[k], 0);
        tick;
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("lit_rst_drop_rvalid", k, rvalid[k], 0);
            chk("lit_rst_after_no_rd", k, ram_rd[k], 0);
        end
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("lit_rst_resume_rd", k, ram_rd[k], 1);
            chk("lit_rst_resume_addr", k, ram_addr[k], 14'd6);
        end
        tick;
        arvalid = 1'b0; rready = 1'b1;
        repeat (4) tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
